// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg: shared types and constants for the data-memory arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CORE   = 2'd0,
    HOST   = 2'd1,
    HALTED = 2'd2
  } arb_state_t;

  localparam int STAT_WIDTH = 16;

  function automatic logic [STAT_WIDTH-1:0] stat_sat_inc(input logic [STAT_WIDTH-1:0] value);
    return (&value) ? value : value + STAT_WIDTH'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// dmem_arb_starve_cnt: saturating count of contended cycles seen by the host. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over increment so a grant in the same cycle restarts the count.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign limit_hit = (r_cnt == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter: core-priority data-memory arbiter with host slot, halt mode and
// optional statistics (macro DMEM_ARB_STATS_EN). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_halt,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_halted,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [STAT_WIDTH-1:0] stat_host_grants,
  output logic [STAT_WIDTH-1:0] stat_core_stalls
);

  arb_state_t r_state;
  arb_state_t w_state_next;

  logic w_host_sel;
  logic w_core_stall;
  logic w_host_ack;
  logic w_halted;
  logic w_limit_hit;
  logic w_starve_inc;
  logic w_starve_clr;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= CORE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_host_sel   = 1'b0;
    w_core_stall = 1'b0;
    w_host_ack   = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      CORE: begin
        if (host_halt) begin
          w_state_next = HALTED;
        end else if (host_req && (!core_req || w_limit_hit)) begin
          w_state_next = HOST;
        end
      end
      HOST: begin
        w_host_sel   = 1'b1;
        w_host_ack   = host_req;
        w_core_stall = core_req;
        w_state_next = host_halt ? HALTED : CORE;
      end
      HALTED: begin
        w_host_sel   = 1'b1;
        w_host_ack   = host_req;
        w_core_stall = 1'b1;
        w_halted     = 1'b1;
        if (!host_halt) begin
          w_state_next = CORE;
        end
      end
      default: begin
        w_state_next = CORE;
      end
    endcase
  end

  assign w_starve_inc = (r_state == CORE) && host_req && core_req;
  assign w_starve_clr = !host_req || (r_state != CORE) || (w_state_next != CORE);

  dmem_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clock     (clock),
    .rstn      (rstn),
    .inc       (w_starve_inc),
    .clr       (w_starve_clr),
    .limit_hit (w_limit_hit)
  );

  // Control outputs are forced quiet while reset is held so the memory never
  // sees a strobe from a core request that arrives during reset.
  assign mem_read    = rstn & (w_host_sel ? (host_req & ~host_we) : (core_req & ~core_we));
  assign mem_write   = rstn & (w_host_sel ? (host_req & host_we) : (core_req & core_we));
  assign mem_address = w_host_sel ? host_addr  : core_addr;
  assign mem_wdata   = w_host_sel ? host_wdata : core_wdata;
  assign core_stall  = rstn & w_core_stall;
  assign host_ack    = rstn & w_host_ack;
  assign host_halted = rstn & w_halted;
  assign core_rdata  = mem_rdata;
  assign host_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] r_host_grants;
  logic [STAT_WIDTH-1:0] r_core_stalls;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_host_grants <= '0;
      r_core_stalls <= '0;
    end else begin
      if (host_ack) begin
        r_host_grants <= stat_sat_inc(r_host_grants);
      end
      if (core_stall && core_req) begin
        r_core_stalls <= stat_sat_inc(r_core_stalls);
      end
    end
  end

  assign stat_host_grants = r_host_grants;
  assign stat_core_stalls = r_core_stalls;
`else
  assign stat_host_grants = '0;
  assign stat_core_stalls = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic        clock;
  logic        rstn;
  logic        core_req;
  logic        core_we;
  logic [9:0]  core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        host_req;
  logic        host_we;
  logic [9:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_halt;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_halted;
  logic        mem_read;
  logic        mem_write;
  logic [9:0]  mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] stat_host_grants;
  logic [15:0] stat_core_stalls;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (10),
    .STARVE_LIMIT (4)
  ) dut (
    .clock            (clock),
    .rstn             (rstn),
    .core_req         (core_req),
    .core_we          (core_we),
    .core_addr        (core_addr),
    .core_wdata       (core_wdata),
    .core_rdata       (core_rdata),
    .core_stall       (core_stall),
    .host_req         (host_req),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_halt        (host_halt),
    .host_ack         (host_ack),
    .host_rdata       (host_rdata),
    .host_halted      (host_halted),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .stat_host_grants (stat_host_grants),
    .stat_core_stalls (stat_core_stalls)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: synchronous write, combinational read.
  always @(posedge clock) begin
    if (mem_write) mem[mem_address] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic smp;
    @(negedge clock);
  endtask

  initial begin
    rstn = 1'b0; core_req = 1'b1; core_we = 1'b1; core_addr = 10'd5; core_wdata = 32'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_halt = 1'b0;

    // Reset with a core store pending
    repeat (2) @(posedge clock);
    smp;
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_core_stall", core_stall, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_halted", host_halted, 0);
    check("rst_stat_grants", stat_host_grants, 0);
    check("rst_stat_stalls", stat_core_stalls, 0);

    // Core store, zero latency
    cyc; rstn = 1'b1; core_req = 1'b1; core_we = 1'b1; core_addr = 10'd5; core_wdata = 32'hDEADBEEF;
    smp;
    check("st_mem_write", mem_write, 1);
    check("st_mem_address", mem_address, 5);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_core_stall", core_stall, 0);
    check("st_halted", host_halted, 0);

    // Host read with idle core
    cyc; core_req = 1'b0; core_we = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 10'd5;
    smp;
    check("hr0_host_ack", host_ack, 0);
    check("hr0_mem_read", mem_read, 0);
    cyc;
    smp;
    check("hr1_host_ack", host_ack, 1);
    check("hr1_mem_read", mem_read, 1);
    check("hr1_mem_address", mem_address, 5);
    check("hr1_host_rdata", host_rdata, 32'hDEADBEEF);
    cyc; host_req = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 10'd5;
    smp;
    check("hr2_core_stall", core_stall, 0);
    check("hr2_host_ack", host_ack, 0);
    check("hr2_core_rdata", core_rdata, 32'hDEADBEEF);

    // Starvation: continuous core reads, host write forced in at cycle 5
    cyc; core_req = 1'b1; core_we = 1'b0; core_addr = 10'd7;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'd9; host_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) cyc;
      smp;
      check($sformatf("sv%0d_core_stall", i), core_stall, 0);
      check($sformatf("sv%0d_host_ack", i), host_ack, 0);
    end
    cyc;
    smp;
    check("sv5_core_stall", core_stall, 1);
    check("sv5_host_ack", host_ack, 1);
    check("sv5_mem_write", mem_write, 1);
    check("sv5_mem_address", mem_address, 9);
    cyc; host_req = 1'b0; host_we = 1'b0;
    smp;
    check("sv6_core_stall", core_stall, 0);
    check("sv6_host_ack", host_ack, 0);
    check("sv6_mem_address", mem_address, 7);

    // Halt burst
    cyc; host_halt = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 10'd9;
    smp;
    check("ha_halted", host_halted, 0);
    check("ha_core_stall", core_stall, 0);
    check("ha_core_rdata", core_rdata, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      cyc; host_req = 1'b1; host_we = 1'b1; host_addr = 10'(i); host_wdata = 32'h11 * (i + 1);
      smp;
      check($sformatf("hb%0d_halted", i), host_halted, 1);
      check($sformatf("hb%0d_host_ack", i), host_ack, 1);
      check($sformatf("hb%0d_core_stall", i), core_stall, 1);
      check($sformatf("hb%0d_mem_write", i), mem_write, 1);
      check($sformatf("hb%0d_mem_address", i), mem_address, i);
    end
    cyc; host_req = 1'b0; host_we = 1'b0; host_halt = 1'b0;
    smp;
    check("hd_halted", host_halted, 1);
    check("hd_host_ack", host_ack, 0);
    check("hd_core_stall", core_stall, 1);
    cyc; core_addr = 10'd1;
    smp;
    check("hc_halted", host_halted, 0);
    check("hc_core_stall", core_stall, 0);
    check("hc_core_rdata", core_rdata, 32'h22);

    // Halt and request together go to HALTED, not HOST
    cyc; core_req = 1'b0; host_halt = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 10'd2;
    smp;
    check("sim0_host_ack", host_ack, 0);
    cyc;
    smp;
    check("sim1_halted", host_halted, 1);
    check("sim1_host_ack", host_ack, 1);
    check("sim1_host_rdata", host_rdata, 32'h33);
`ifdef DMEM_ARB_STATS_EN
    check("pre_stat_grants", stat_host_grants, 5);
    check("pre_stat_stalls", stat_core_stalls, 5);
`endif

    // Asynchronous reset in HALTED
    #1; rstn = 1'b0; host_halt = 1'b0; host_req = 1'b0;
    #1;
    check("ar_halted", host_halted, 0);
    check("ar_host_ack", host_ack, 0);
    check("ar_core_stall", core_stall, 0);
    check("ar_stat_grants", stat_host_grants, 0);
    check("ar_stat_stalls", stat_core_stalls, 0);
    cyc; rstn = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 10'd2;
    smp;
    check("post_core_stall", core_stall, 0);
    check("post_mem_read", mem_read, 1);
    check("post_core_rdata", core_rdata, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the core datapath and a host/debug port, such as a loader or test harness. The core has priority. A starvation counter guarantees the host a slot, and a halt mode freezes the core so the host can access memory every cycle. The block sits between the datapath's memory-side signals (`memRead`, `memWrite`, word address, store data) and the `dataMemory` instance. Its `core_stall` output gates the PC register and `regWrite` in the datapath.

## Interface
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 10: word address width, matching the `aluOut[11:2]` memory addressing.
- `STARVE_LIMIT`, 4: number of contended cycles before the host is forced in. Must be ≥1.
- `clock` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `core_req` input 1: the core needs memory this cycle (`memRead` | `memWrite`).
- `core_we` input 1: the core access is a store.
- `core_addr` input ADDR_WIDTH: core word address.
- `core_wdata` input DATA_WIDTH: core store data.
- `core_rdata` output DATA_WIDTH: load data returned to the core.
- `core_stall` output 1: the core access is not granted; the core holds PC and suppresses `regWrite`.
- `host_req` input 1: host access request; held stable until `host_ack`.
- `host_we`, `host_addr`, `host_wdata` inputs 1/ADDR_WIDTH/DATA_WIDTH: host access attributes.
- `host_halt` input 1: level request to freeze the core.
- `host_ack` output 1: the host access is performed this cycle.
- `host_rdata` output DATA_WIDTH: valid when `host_ack`.
- `host_halted` output 1: the FSM is in HALTED.
- `mem_read`, `mem_write` outputs 1: to `dataMemory` `memRead`/`memWrite`.
- `mem_address` output ADDR_WIDTH: memory word address.
- `mem_wdata` output DATA_WIDTH: memory store data.
- `mem_rdata` input DATA_WIDTH: combinational read data from memory.
- `stat_host_grants`, `stat_core_stalls` outputs 16: statistics counters (see Configuration).

## Operation
- The FSM has three states: CORE, HOST and HALTED. The reset state is CORE.
- **CORE**:
  - The memory port is muxed to the core, with `mem_read` = `core_req`&!`core_we` and `mem_write` = `core_req`&`core_we`.
  - `core_stall` = 0 and `host_ack` = 0.
- **HOST**:
  - The port is muxed to the host, with `mem_read`/`mem_write` qualified by `host_req`.
  - `host_ack` = `host_req` and `core_stall` = `core_req`.
- **HALTED**:
  - The port is muxed to the host, with `host_ack` = `host_req` every cycle.
  - `core_stall` = 1 and `host_halted` = 1.
- Transitions, evaluated at each clock edge:
  - From CORE: to HALTED if `host_halt`, which has priority. Otherwise to HOST if `host_req` & (!`core_req` | `starve_cnt` == `STARVE_LIMIT`). Otherwise stay in CORE.
  - From HOST: to HALTED if `host_halt`, otherwise to CORE. HOST always lasts exactly one cycle.
  - From HALTED: to CORE when `host_halt` = 0.
- Starvation counter:
  - `starve_cnt` is $clog2(STARVE_LIMIT+1) bits wide.
  - In CORE it increments each cycle that `host_req`&`core_req` holds, saturating at `STARVE_LIMIT`.
  - It clears to 0 on entering HOST or HALTED, and when `host_req` = 0.
- `core_rdata` = `mem_rdata` and `host_rdata` = `mem_rdata`, unregistered.
- Read data is valid only for the owner of the current cycle.

## Timing
- While `rstn` = 0:
  - The FSM is held in CORE and `starve_cnt` = 0.
  - `mem_read` = `mem_write` = 0, and `core_stall`, `host_ack`, `host_halted` = 0.
  - Statistics counters = 0.
- Core access has zero latency when no host slot is scheduled. A store commits at the clock edge that ends the access cycle.
- Host latency is at least 1 cycle in CORE: a request in cycle n gets `host_ack` in cycle n+1 if the core is idle in cycle n.
- Under continuous core traffic, host latency is `STARVE_LIMIT`+1 cycles.
- In HALTED, host accesses complete back-to-back with 0 added latency.
- If the host drops `host_req` before ack, no memory access occurs, and a HOST cycle without request is a wasted slot.
- Reset asserted in any state returns the FSM to CORE immediately (asynchronous). No partial write occurs because writes happen only at clock edges with `rstn` = 1.

## Configuration
- Macro: `DMEM_ARB_STATS_EN`.
- Defined:
  - `stat_host_grants` increments on each cycle with `host_ack` = 1.
  - `stat_core_stalls` increments on each cycle with `core_stall`&`core_req`.
  - Both counters are 16-bit, saturating, and cleared only by reset.
- Undefined: both outputs are tied to 0, with no counter flops.

## Structure
- Package `dmem_arb_pkg`:
  - FSM state enum (CORE=2'd0, HOST=2'd1, HALTED=2'd2).
  - `STAT_WIDTH` = 16.
- Sub-module `dmem_arb_starve_cnt`: the saturating starvation counter, with increment, clear and limit-hit ports.
- The port mux and the FSM live in the top module.

## Test plan
- **Reset:** hold `rstn` = 0 with `core_req` = 1 and `core_we` = 1 → `mem_write` = 0, `core_stall` = 0, `host_ack` = 0. Release → state CORE.
- **Core store:** `core_req` = 1, `core_we` = 1, `core_addr` = 5, `core_wdata` = 32'hDEADBEEF → same cycle `mem_write` = 1, `mem_address` = 5, `core_stall` = 0.
- **Host read, core idle:** `host_req` = 1, `host_we` = 0, `host_addr` = 5 in cycle 0 → `host_ack` = 1 in cycle 1 with `host_rdata` = 32'hDEADBEEF, then return to CORE.
- **Starvation:** `STARVE_LIMIT` = 4, `core_req` = 1 continuously, `host_req` from cycle 0 → HOST in cycle 5, with `core_stall` = 1 only in cycle 5 and `host_ack` in cycle 5.
- **Halt burst:** assert `host_halt` → `host_halted` = 1 next cycle. Three host writes to addr 0, 1, 2 are each acked in consecutive cycles while `core_stall` = 1. Deassert `host_halt` → CORE next cycle, `core_stall` = 0.
- **Simultaneous events:** `host_halt` and `host_req` together in CORE → HALTED, not HOST. Assert `rstn` = 0 mid-HALTED → CORE, `host_halted` = 0 immediately. With `DMEM_ARB_STATS_EN`, confirm the counts from the prior steps before reset, then 0 after.
